// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch queue.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_QDEPTH = 2;
  localparam int QCNT_W       = $clog2(FETCH_QDEPTH + 1);
  localparam logic [QCNT_W-1:0] QFULL = QCNT_W'(FETCH_QDEPTH);
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr} pairs; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      din,
  output logic [QCNT_W-1:0] count,
  output fetch_entry_t      head
);

  fetch_entry_t mem [FETCH_QDEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + QCNT_W'(push) - QCNT_W'(pop);
    end
  end

  // Storage is never reset, so the head is gated to keep outputs clean when empty.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational ROM and feeds decode via the prefetch queue.
//   state  | meaning
//   RUN    | fetching one instruction per cycle while the queue has room
//   HALTED | PC frozen, no fetches; queued entries still drain to decode
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  input  logic                  halt_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [31:0]           pc_o,
  output logic                  halted_o
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              push, pop;
  logic [QCNT_W-1:0] q_count;
  fetch_entry_t      q_din, q_head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pop = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      RUN: begin
        if (!redirect_i && halt_i) state_d = HALTED;
        push = !redirect_i && ((q_count < QFULL) || pop);
      end
      HALTED: begin
        if (redirect_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Redirect beats fetch; the low two target bits are dropped to keep word alignment.
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~32'h3;
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  assign q_din.pc    = pc_q;
  assign q_din.instr = imem_data_i;

  fetch_queue u_queue (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .din   (q_din),
    .count (q_count),
    .head  (q_head)
  );

  assign imem_addr_o = pc_q[ADDR_WIDTH-1:0];
  assign valid_o     = (q_count != '0);
  assign instr_o     = q_head.instr[DATA_WIDTH-1:0];
  assign pc_o        = q_head.pc;
  assign halted_o    = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural ROM where word i = 32'h1000_0000 + i.
module tb_instr_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        halted_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  assign imem_data = 32'h1000_0000 + 32'(imem_addr >> 2);

  instr_fetch_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .halted_o      (halted_o)
  );

  // Advance one edge; sampling and driving both happen 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_i = 1'b1; ready_i = rdy; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ready_i = 1'b1; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    n_cmp++;
    if ({valid_o, halted_o, pc_o, instr_o, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 10'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b h=%b pc=%h ins=%h addr=%h, want 0 0 0 0 0",
               valid_o, halted_o, pc_o, instr_o, imem_addr);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h, want 1 %h %h",
                 i, valid_o, pc_o, instr_o, 32'(4 * i), 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] eaddr;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      eaddr = (i == 0) ? 10'd4 : 10'd8;
      n_cmp++;
      if ({valid_o, pc_o, instr_o, imem_addr} !== {1'b1, 32'h0, 32'h1000_0000, eaddr}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b pc=%h ins=%h addr=%h, want 1 0 10000000 %h",
                 i, valid_o, pc_o, instr_o, imem_addr, eaddr);
      end
    end
    ready_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)}) begin
        n_fail++;
        $display("FAIL release[%0d]: got v=%b pc=%h ins=%h, want 1 %h", k, valid_o, pc_o, instr_o, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step(); step();               // queue now holds pc 0 and pc 4
    ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043;
    step();
    redirect_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_bubble: got v=%b, want 0", valid_o);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h40, 32'h1000_0010}) begin
      n_fail++;
      $display("FAIL redir_target: got v=%b pc=%h ins=%h, want 1 40 10000010", valid_o, pc_o, instr_o);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h44, 32'h1000_0011}) begin
      n_fail++;
      $display("FAIL redir_next: got v=%b pc=%h ins=%h, want 1 44 10000011", valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    step(); step(); step();       // head pc 8, pc 12 being fetched
    n_cmp++;
    if ({valid_o, pc_o, imem_addr} !== {1'b1, 32'h8, 10'd12}) begin
      n_fail++;
      $display("FAIL halt_pre: got v=%b pc=%h addr=%h, want 1 8 00c", valid_o, pc_o, imem_addr);
    end
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    n_cmp++;
    if ({halted_o, valid_o, pc_o} !== {1'b1, 1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL halt_drain: got h=%b v=%b pc=%h, want 1 1 c", halted_o, valid_o, pc_o);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({halted_o, valid_o, imem_addr} !== {1'b1, 1'b0, 10'd16}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got h=%b v=%b addr=%h, want 1 0 010", i, halted_o, valid_o, imem_addr);
      end
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step();
    redirect_i = 1'b0;
    step();
    n_cmp++;
    if ({halted_o, valid_o, pc_o, instr_o} !== {1'b0, 1'b1, 32'h0, 32'h1000_0000}) begin
      n_fail++;
      $display("FAIL halt_resume: got h=%b v=%b pc=%h ins=%h, want 0 1 0 10000000",
               halted_o, valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_halt_redirect();
    do_reset(1'b1);
    step();
    halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step();
    halt_i = 1'b0; redirect_i = 1'b0;
    n_cmp++;
    if ({halted_o, valid_o} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hr_state: got h=%b v=%b, want 0 0", halted_o, valid_o);
    end
    step();
    n_cmp++;
    if ({halted_o, valid_o, pc_o, instr_o} !== {1'b0, 1'b1, 32'h20, 32'h1000_0008}) begin
      n_fail++;
      $display("FAIL hr_target: got h=%b v=%b pc=%h ins=%h, want 0 1 20 10000008",
               halted_o, valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    n_cmp++;
    if ({valid_o, imem_addr} !== {1'b0, 10'h3FC}) begin
      n_fail++;
      $display("FAIL wrap_addr: got v=%b addr=%h, want 0 3fc", valid_o, imem_addr);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h1000_00FF, 10'h0}) begin
      n_fail++;
      $display("FAIL wrap_top: got v=%b pc=%h ins=%h addr=%h, want 1 fffffffc 100000ff 000",
               valid_o, pc_o, instr_o, imem_addr);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      n_fail++;
      $display("FAIL wrap_zero: got v=%b pc=%h ins=%h, want 1 0 10000000", valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    step(); step(); step();       // queue full, pc_q at 8
    ready_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_cmp++;
    if ({valid_o, pc_o, imem_addr, halted_o} !== {1'b0, 32'h0, 10'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b pc=%h addr=%h h=%b, want 0 0 0 0", valid_o, pc_o, imem_addr, halted_o);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      n_fail++;
      $display("FAIL midrst_restart: got v=%b pc=%h ins=%h, want 1 0 10000000", valid_o, pc_o, instr_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; ready_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
